// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encoding and the baud divisor,
// so transmitter and receiver derive an identical bit period.
package uart_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    function automatic int bit_ticks(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous inputs,
// with a parameterised reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM with registered byte output,
// completion strobe and framing-error strobe.
module uart_rx
    import uart_defs::*;
#(
    parameter int CLOCK_HZ = 10_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Rx_i,
    output logic [7:0] Data_o,
    output logic       Done_o,
    output logic       Busy_o,
    output logic       Error_o
);

    localparam int BIT_TICKS  = bit_ticks(CLOCK_HZ, BAUD);
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CW         = $clog2(BIT_TICKS);

    localparam logic [CW-1:0] BIT_END  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_TICKS - 1);

    logic          rx_s;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          done_p;
    logic          err_p;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .Clock (Clock),
        .Reset (Reset),
        .d     (Rx_i),
        .q     (rx_s)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            done_p <= 1'b0;
            err_p  <= 1'b0;
        end else begin
            done_p <= 1'b0;
            err_p  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7)
                            state <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_END) begin
                        cnt    <= '0;
                        done_p <= rx_s;
                        err_p  <= !rx_s;
                        state  <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Wait out a held-low line so it cannot retrigger.
                    if (rx_s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Data_o  <= 8'h00;
            Done_o  <= 1'b0;
            Error_o <= 1'b0;
            Busy_o  <= 1'b0;
        end else begin
            Done_o  <= done_p;
            Error_o <= err_p;
            Busy_o  <= (state != ST_IDLE);
            if (done_p)
                Data_o <= shreg;
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the team's `UART_TX`. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the asynchronous serial line. Each received byte is presented on a parallel output with a one-cycle completion strobe. It sits between the board RX pin and byte-level consumers such as command parsers and FIFOs, using the same `CLOCK_HZ`/`BAUD` parameterisation as the transmitter.

## Interface
- `CLOCK_HZ`, default 10_000_000, system clock frequency in Hz.
- `BAUD`, default 115200, line bit rate.
- `Clock`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Rx_i`  in  1  serial line, asynchronous to `Clock`, idles high.
- `Data_o`  out  8  last correctly received byte; holds until the next good frame.
- `Done_o`  out  1  one-cycle strobe: `Data_o` updated this cycle.
- `Busy_o`  out  1  high while a frame is in progress (any state other than IDLE).
- `Error_o`  out  1  one-cycle strobe: framing error (stop bit sampled low).

## Operation
- Derived constants:
  - `BIT_TICKS = CLOCK_HZ / BAUD`, integer division, so 86 at the defaults.
  - `HALF_TICKS = BIT_TICKS / 2`, so 43 at the defaults.
  - Tick counter width is `$clog2(BIT_TICKS)`.
- `Rx_i` passes through a 2-FF synchronizer. Both FFs reset to 1. All decisions use the synchronized signal `rx_s`.
- States:
  - IDLE: wait for `rx_s` = 0, then clear the tick counter and go to START.
  - START: at tick `HALF_TICKS-1`, sample `rx_s`.
    - 0: clear the counter and the bit index, go to DATA.
    - 1: glitch; return to IDLE with no strobe.
  - DATA: every `BIT_TICKS`, sample `rx_s` into the shift register, MSB-in / shift right, so LSB is received first. After bit index 7, go to STOP.
  - STOP: after `BIT_TICKS`, sample `rx_s`.
    - 1: load the shift register into `Data_o`, pulse `Done_o`, go to IDLE.
    - 0: pulse `Error_o`, leave `Data_o` unchanged, go to BREAK.
  - BREAK: wait for `rx_s` = 1, then go to IDLE. A held-low line does not produce repeated frames or errors.
- Reset values: `Data_o` = 0x00, `Done_o` = 0, `Error_o` = 0, `Busy_o` = 0, state IDLE, counters 0, synchronizer 1.
- An asserted `Reset` mid-frame aborts immediately and produces no strobe. After release, reception restarts at IDLE. If the line is low at release, the remainder of that frame is treated as a new start.
- `Done_o` and `Error_o` are never high in the same cycle.

## Timing
- t0 is the first `Clock` edge at which `rx_s` = 0 is observed in IDLE; `rx_s` lags `Rx_i` by 2 cycles.
- Start sample at t0+43.
- Data bit k (k = 0..7) sampled at t0+43+86·(k+1).
- Stop sample at t0+817.
- `Done_o`/`Error_o` are registered and high during the cycle after the stop sample, i.e. t0+818. `Data_o` changes on that same edge.
- `Busy_o` goes high at t0+1 and low at t0+818.
- The receiver is back in IDLE at t0+818 and accepts a new start edge from t0+818 onward. Back-to-back frames with no idle gap are supported, since the stop-bit sample falls mid-bit, half a bit ahead of the next start.
- Mid-bit sampling tolerates a baud mismatch of about ±4 %.

## Structure
- Shared package/include `uart_defs`:
  - state encoding localparams (IDLE, START, DATA, STOP, BREAK);
  - the `BIT_TICKS` formula, so TX and RX use an identical divisor.
- Sub-module `sync_2ff`: generic 1-bit two-flop synchronizer with a parameterised reset value (1 here). It is reusable for other asynchronous inputs.
- Everything else lives in one always block for the FSM plus counters, and one for the output registers.

## Test plan
All scenarios use `CLOCK_HZ` = 10_000_000, `BAUD` = 115200 and an 86-cycle bit period driven by the bench.
- Send 0xA5 after idle → `Done_o` is a single 1-cycle pulse at t0+818 with `Data_o` = 0xA5. `Error_o` stays 0 and `Busy_o` is high for 817 cycles.
- Send 0x00 then 0xFF with no idle gap → two `Done_o` pulses 860 cycles apart, with `Data_o` = 0x00 then 0xFF.
- Low glitch of 20 cycles on idle line → no `Done_o` or `Error_o`; `Busy_o` drops at t0+44; a following 0x3C frame is received correctly.
- Frame 0x55 with stop bit driven 0, line then held low for 2000 cycles → exactly one `Error_o` pulse at t0+818 and `Data_o` keeps its previous value. After the line returns high, frame 0x81 is received as 0x81.
- Assert `Reset` during data bit 4 of 0xC3 → all outputs 0 immediately and no strobe. After release on an idle line, frame 0x7E is received as 0x7E.
- Bench bit period of 83 and 90 cycles (about ±4 %) sending 0x96 → `Data_o` = 0x96, `Done_o` pulses, no `Error_o`.
